// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution front-end.
// Holds the sequencer state encoding and pixel type.
// No logic; imported by the sequencer and its counter.
package conv_pkg;

  localparam int IMAGE_WIDTH = 512;
  localparam int PIXEL_DATAW = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TOP  = 3'd1,
    LPAD = 3'd2,
    PIX  = 3'd3,
    RPAD = 3'd4,
    BOT  = 3'd5
  } seq_state_t;

  typedef logic [PIXEL_DATAW-1:0] pixel_t;

endpackage

// File: rtl/pad_pos_counter.sv
// Column/row position inside the zero-padded frame (W+2 columns, H+2 rows).
// Flags are combinational from registered counters; counts advance one cycle after i_en.
// No handshake of its own: it only moves when the parent signals a transfer.
module pad_pos_counter #(
  parameter int IMG_W = conv_pkg::IMAGE_WIDTH,
  parameter int HGT_W = 16,
  parameter int COL_W = $clog2(IMG_W + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [HGT_W-1:0] i_height,
  output logic             o_col_last,
  output logic             o_pix_last,
  output logic             o_row_img_last,
  output logic             o_frame_last
);

  logic [COL_W-1:0] r_col;
  logic [HGT_W:0]   r_row;
  logic [HGT_W:0]   w_height_ext;
  logic [HGT_W:0]   w_height_p1;

  // Row counter is one bit wider than the height so row H+1 is representable.
  assign w_height_ext   = {1'b0, i_height};
  assign w_height_p1    = w_height_ext + (HGT_W+1)'(1);

  assign o_col_last     = (r_col == COL_W'(IMG_W + 1));
  assign o_pix_last     = (r_col == COL_W'(IMG_W));
  assign o_row_img_last = (r_row == w_height_ext);
  assign o_frame_last   = o_col_last && (r_row == w_height_p1);

  // Step column per transfer; wrap at the right pad and bump the row, clearing at frame end.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (o_col_last) begin
        r_col <= '0;
        r_row <= o_frame_last ? '0 : r_row + (HGT_W+1)'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Wraps a raw W x H pixel stream with a one-pixel zero border for the 3x3 conv core.
// Zero-latency: pixels pass combinationally from s_* to m_* in the PIX state.
// m_ready stalls everything; s_ready depends only on state and m_ready, never on s_valid.
module conv_frame_sequencer #(
  parameter int IMAGE_WIDTH = conv_pkg::IMAGE_WIDTH,
  parameter int PIXEL_DATAW = conv_pkg::PIXEL_DATAW,
  parameter int HEIGHT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [HEIGHT_W-1:0]    i_height,
  input  logic                   i_abort,
  input  logic                   s_valid,
  input  logic [PIXEL_DATAW-1:0] s_x,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [PIXEL_DATAW-1:0] m_x,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   o_busy,
  output logic                   o_done
);

  import conv_pkg::*;

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [HEIGHT_W-1:0] r_height;
  logic                r_busy;
  logic                r_done;

  logic w_start_ok;
  logic w_abort;
  logic w_xfer;
  logic w_col_last;
  logic w_pix_last;
  logic w_row_img_last;
  logic w_frame_last;

  // A zero-height request is not a frame; abort only matters once a frame is running.
  assign w_start_ok = (r_state == IDLE) && i_start && (i_height != '0);
  assign w_abort    = i_abort && (r_state != IDLE);

  // Pad beats are always valid zeros; pixel beats mirror the producer.
  assign m_valid = (r_state == PIX) ? s_valid : (r_state != IDLE);
  assign m_x     = (r_state == PIX) ? s_x : '0;
  assign s_ready = (r_state == PIX) && m_ready;
  assign m_last  = (r_state == BOT) && w_frame_last;
  assign w_xfer  = m_valid && m_ready;

  assign o_busy  = r_busy;
  assign o_done  = r_done;

  pad_pos_counter #(
    .IMG_W (IMAGE_WIDTH),
    .HGT_W (HEIGHT_W)
  ) u_pos (
    .clk            (clk),
    .reset          (reset),
    .i_clr          (w_abort),
    .i_en           (w_xfer),
    .i_height       (r_height),
    .o_col_last     (w_col_last),
    .o_pix_last     (w_pix_last),
    .o_row_img_last (w_row_img_last),
    .o_frame_last   (w_frame_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: every non-idle state advances only on a transferred beat; abort wins.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start_ok)                 w_state_nxt = TOP;
      TOP:  if (w_xfer && w_col_last)       w_state_nxt = LPAD;
      LPAD: if (w_xfer)                     w_state_nxt = PIX;
      PIX:  if (w_xfer && w_pix_last)       w_state_nxt = RPAD;
      RPAD: if (w_xfer)                     w_state_nxt = w_row_img_last ? BOT : LPAD;
      BOT:  if (w_xfer && w_frame_last)     w_state_nxt = IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = IDLE;
    end
  end

  // Height is captured once per frame so mid-frame changes on i_height are harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_height <= '0;
    end else if (w_start_ok) begin
      r_height <= i_height;
    end
  end

  // Busy spans accepted start through the final beat; done pulses only on natural completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && m_last && !w_abort;
      if (w_abort) begin
        r_busy <= 1'b0;
      end else if (w_start_ok) begin
        r_busy <= 1'b1;
      end else if (w_xfer && m_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboarded bench: W=4 instance for the directed scenarios, default W=512 for back-to-back.
// Stimulus is applied 1ns after the rising edge; monitors sample on the falling edge.
// Expected beats are queued by the stimulus and consumed by the monitors.
module tb_conv_frame_sequencer;

  localparam int W  = 4;
  localparam int HW = 16;
  localparam int BW = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // W=4 instance signals
  logic          start, abort_r, s_valid, s_ready, m_valid, m_ready, m_last, busy, done;
  logic [HW-1:0] height;
  logic [7:0]    s_x, m_x;

  // W=512 instance signals
  logic          b_start, b_abort, b_svalid, b_sready, b_mvalid, b_mready, b_mlast, b_busy, b_done;
  logic [HW-1:0] b_height;
  logic [7:0]    b_sx, b_mx;

  conv_frame_sequencer #(.IMAGE_WIDTH(W), .PIXEL_DATAW(8), .HEIGHT_W(HW)) dut4 (
    .clk(clk), .reset(reset), .i_start(start), .i_height(height), .i_abort(abort_r),
    .s_valid(s_valid), .s_x(s_x), .s_ready(s_ready),
    .m_valid(m_valid), .m_x(m_x), .m_ready(m_ready), .m_last(m_last),
    .o_busy(busy), .o_done(done));

  conv_frame_sequencer dut512 (
    .clk(clk), .reset(reset), .i_start(b_start), .i_height(b_height), .i_abort(b_abort),
    .s_valid(b_svalid), .s_x(b_sx), .s_ready(b_sready),
    .m_valid(b_mvalid), .m_x(b_mx), .m_ready(b_mready), .m_last(b_mlast),
    .o_busy(b_busy), .o_done(b_done));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  typedef struct packed { logic [7:0] x; logic last; } beat_t;
  beat_t      exp_q[$];
  logic [7:0] pix_q[$];

  int   beats = 0, done_cnt = 0, sr_cnt = 0, cyc = 0, last_cyc = 0, done_cyc = 0;
  bit   mode_rand = 0, mode_tog = 0, hold_mr0 = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_x = '0;

  // W=4 monitor: pops expected beats on every transfer, checks stall stability.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && m_valid) chk("stable_x", m_x, prev_x);
      prev_stall = m_valid && !m_ready;
      prev_x     = m_x;
      if (s_ready) sr_cnt++;
      if (s_valid && s_ready && pix_q.size() > 0) void'(pix_q.pop_front());
      if (m_valid && m_ready) begin
        beats++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got beat %0d x=%0d want none", beats, m_x);
        end else begin
          e = exp_q.pop_front();
          if (m_x !== e.x || m_last !== e.last) begin
            bad++;
            $display("FAIL beat%0d: got x=%0d last=%0d want x=%0d last=%0d",
                     beats, m_x, m_last, e.x, e.last);
          end
        end
        if (m_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // W=512 monitor: expected value derived from the beat index within the frame.
  int   b_beat = 0, b_pix = 0, b_frames = 0, b_gap = 0, b_tot = 0;
  assign b_sx = 8'(b_pix + 1);

  always @(negedge clk) begin
    int r, c;
    logic [7:0] ex;
    if (!reset) begin
      if (b_mvalid && b_mready) begin
        r  = b_beat / (BW + 2);
        c  = b_beat % (BW + 2);
        ex = (r >= 1 && r <= 2 && c >= 1 && c <= BW) ? 8'((r - 1) * BW + c) : 8'd0;
        total++;
        if (b_mx !== ex || b_mlast !== (b_beat == (BW + 2) * 4 - 1)) begin
          bad++;
          $display("FAIL w512_beat%0d: got x=%0d last=%0d want x=%0d", b_beat, b_mx, b_mlast, ex);
        end
        b_beat++;
        b_tot++;
        if (b_mlast) begin
          b_frames++;
          b_beat = 0;
          b_pix  = 0;
        end
      end else if (b_frames == 1 && !b_mvalid) begin
        b_gap++;
      end
      if (b_svalid && b_sready) b_pix++;
    end
  end

  // One clock of stimulus for the W=4 instance.
  task automatic cycle();
    @(posedge clk);
    #1;
    s_valid = (pix_q.size() > 0) && (mode_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    s_x     = (pix_q.size() > 0) ? pix_q[0] : 8'd0;
    m_ready = hold_mr0 ? 1'b0 : (mode_tog ? ~m_ready : 1'b1);
  endtask

  task automatic push_frame(input int h);
    int p = 1;
    beat_t e;
    for (int r = 0; r < h + 2; r++) begin
      for (int c = 0; c < W + 2; c++) begin
        if (r >= 1 && r <= h && c >= 1 && c <= W) begin
          e.x = 8'(p);
          pix_q.push_back(8'(p));
          p++;
        end else begin
          e.x = 8'd0;
        end
        e.last = (r == h + 1) && (c == W + 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input int h);
    height = HW'(h);
    start  = 1'b1;
    cycle();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (done_cnt != d0) break;
    end
    chk({name, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (beats >= target) break;
      cycle();
    end
    chk("wait_beats", beats, target);
  endtask

  initial begin
    int b0, d0;
    reset = 1; start = 0; abort_r = 0; height = '0; s_valid = 0; s_x = '0; m_ready = 1;
    b_start = 0; b_abort = 0; b_height = '0; b_svalid = 1; b_mready = 1;
    repeat (3) cycle();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;
    cycle();

    // Frame H=2, continuous flow
    sr_cnt = 0; b0 = beats;
    push_frame(2);
    start_frame(2);
    chk("t1_busy_up", busy, 1);
    wait_done("t1", 80);
    chk("t1_beats", beats - b0, 24);
    chk("t1_exp_left", exp_q.size(), 0);
    chk("t1_pix_left", pix_q.size(), 0);
    chk("t1_sready_cycles", sr_cnt, 8);
    chk("t1_done_lat", done_cyc - last_cyc, 1);
    chk("t1_busy_down", busy, 0);
    chk("t1_done_pulse", done, 0);

    // Same frame with m_ready toggling and random s_valid
    b0 = beats; mode_rand = 1; mode_tog = 1;
    push_frame(2);
    start_frame(2);
    wait_done("t2", 300);
    mode_rand = 0; mode_tog = 0;
    chk("t2_beats", beats - b0, 24);
    chk("t2_exp_left", exp_q.size(), 0);
    chk("t2_pix_left", pix_q.size(), 0);
    cycle();

    // Zero height is ignored, then H=1
    b0 = beats; d0 = done_cnt;
    start_frame(0);
    repeat (5) cycle();
    chk("t3_busy", busy, 0);
    chk("t3_no_beats", beats - b0, 0);
    chk("t3_no_done", done_cnt - d0, 0);
    push_frame(1);
    start_frame(1);
    wait_done("t3b", 60);
    chk("t3b_beats", beats - b0, 18);
    chk("t3b_exp_left", exp_q.size(), 0);

    // Abort in second pixel row after two pixels (beat 15 = pixel 7 goes with the abort)
    cycle();
    b0 = beats; d0 = done_cnt;
    push_frame(3);
    start_frame(3);
    wait_beats(b0 + 15, 60);
    abort_r = 1;
    cycle();
    abort_r = 0;
    chk("t4_busy", busy, 0);
    chk("t4_m_valid", m_valid, 0);
    chk("t4_exp_left", exp_q.size(), 30 - 16);
    chk("t4_pix_left", pix_q.size(), 5);
    exp_q.delete(); pix_q.delete();
    repeat (3) cycle();
    chk("t4_no_done", done_cnt - d0, 0);
    b0 = beats;
    push_frame(1);
    start_frame(1);
    wait_done("t4b", 60);
    chk("t4b_beats", beats - b0, 18);
    chk("t4b_exp_left", exp_q.size(), 0);

    // Reset while stalled in the bottom pad row
    cycle();
    b0 = beats;
    push_frame(1);
    start_frame(1);
    wait_beats(b0 + 12, 60);
    hold_mr0 = 1; m_ready = 1'b0;
    cycle(); cycle();
    chk("t5_bot_valid", m_valid, 1);
    chk("t5_exp_left", exp_q.size(), 6);
    reset = 1;
    cycle();
    reset = 0;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_s_ready", s_ready, 0);
    exp_q.delete(); pix_q.delete();
    hold_mr0 = 0;
    cycle();

    // Default width, back-to-back frames with restart on the done cycle
    b_height = HW'(2);
    b_start  = 1'b1;
    cycle();
    b_start  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (b_done) begin
        b_start = 1'b1;
        cycle();
        b_start = 1'b0;
        break;
      end
    end
    chk("w512_restart_busy", b_busy, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (b_done) break;
    end
    chk("w512_done2", b_done, 1);
    cycle();
    chk("w512_frames", b_frames, 2);
    chk("w512_beats", b_tot, 2 * (BW + 2) * 4);
    chk("w512_gap", b_gap, 1);
    chk("w512_busy", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
